reflex_trigger_conditioner: RTL and testbench

- Sits between the network controller's `reflex_trig` output and the CIM core's `trigger_in` input.
- Edge-detects raw reflex events and issues fixed-width trigger pulses to CIM.
- Queues at most one event while CIM is busy, waits for CIM completion, then enforces a programmable holdoff before re-arming.
- Software-visible AHB-Lite slave for config, status, issued/dropped counters; one new interconnect slave port.

---
 rtl/reflex_pkg.sv | 19 +
 rtl/reflex_ahb_regs.sv | 109 ++++++++++
 rtl/reflex_trigger_conditioner.sv | 172 +++++++++++++++++
 tb/tb_reflex_trigger_conditioner.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reflex_pkg.sv
// Shared state encoding and register map for the reflex trigger conditioner.
package reflex_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StWait = 2'd2,
        StHold = 2'd3
    } reflex_state_e;

    localparam logic [4:0]  OffCtrl    = 5'h00;
    localparam logic [4:0]  OffHoldoff = 5'h04;
    localparam logic [4:0]  OffStatus  = 5'h08;
    localparam logic [4:0]  OffIssued  = 5'h0C;
    localparam logic [4:0]  OffDropped = 5'h10;

    localparam logic [15:0] HoldoffRst = 16'd100;

endpackage

// File: rtl/reflex_ahb_regs.sv
// Zero-wait AHB-Lite slave holding the config registers and muxing status for readback.
module reflex_ahb_regs
    import reflex_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic                  hsel,
    input  logic                  hready_in,
    output logic                  hready_out,
    output logic                  hresp,
    output logic                  ctrl_en,
    output logic                  ctrl_irq_en,
    output logic [15:0]           holdoff,
    output logic                  clr_issued,
    output logic                  clr_dropped,
    output logic                  clr_sticky,
    input  logic [1:0]            st_state,
    input  logic                  st_pending,
    input  logic                  st_sticky,
    input  logic [CNT_WIDTH-1:0]  issued,
    input  logic [CNT_WIDTH-1:0]  dropped
);

    logic                  acc;
    logic                  wr_q, wr_d;
    logic [2:0]            widx_q, widx_d;
    logic                  en_q, en_d;
    logic                  irq_en_q, irq_en_d;
    logic [15:0]           holdoff_q, holdoff_d;
    logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;
    logic [DATA_WIDTH-1:0] rd_val;
    logic                  unused_bus;

    assign acc = hsel & htrans[1] & hready_in;
    assign unused_bus = ^{haddr[ADDR_WIDTH-1:5], haddr[1:0], hwdata[DATA_WIDTH-1:16], htrans[0]};

    always_comb begin
        rd_val = '0;
        case ({haddr[4:2], 2'b00})
            OffCtrl:    rd_val[1:0] = {irq_en_q, en_q};
            OffHoldoff: rd_val[15:0] = holdoff_q;
            OffStatus:  rd_val[3:0] = {st_sticky, st_pending, st_state};
            OffIssued:  rd_val[CNT_WIDTH-1:0] = issued;
            OffDropped: rd_val[CNT_WIDTH-1:0] = dropped;
            default:    rd_val = '0;
        endcase
    end

    // Address phase is latched here; the write lands at the end of the data phase.
    always_comb begin
        wr_d        = acc & hwrite;
        widx_d      = haddr[4:2];
        hrdata_d    = (acc && !hwrite) ? rd_val : '0;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        holdoff_d   = holdoff_q;
        clr_issued  = 1'b0;
        clr_dropped = 1'b0;
        clr_sticky  = 1'b0;
        if (wr_q) begin
            case ({widx_q, 2'b00})
                OffCtrl: begin
                    en_d     = hwdata[0];
                    irq_en_d = hwdata[1];
                end
                OffHoldoff: holdoff_d   = hwdata[15:0];
                OffStatus:  clr_sticky  = hwdata[3];
                OffIssued:  clr_issued  = 1'b1;
                OffDropped: clr_dropped = 1'b1;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q      <= 1'b0;
            widx_q    <= 3'd0;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            holdoff_q <= HoldoffRst;
            hrdata_q  <= '0;
        end else begin
            wr_q      <= wr_d;
            widx_q    <= widx_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            holdoff_q <= holdoff_d;
            hrdata_q  <= hrdata_d;
        end
    end

    assign hrdata      = hrdata_q;
    assign hready_out  = 1'b1;
    assign hresp       = 1'b0;
    assign ctrl_en     = en_q;
    assign ctrl_irq_en = irq_en_q;
    assign holdoff     = holdoff_q;

endmodule

// File: rtl/reflex_trigger_conditioner.sv
// Conditions raw reflex events into fixed-width CIM trigger pulses with one-deep queueing,
// completion wait with timeout, and a programmable re-arm holdoff.
module reflex_trigger_conditioner
    import reflex_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned PULSE_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [DATA_WIDTH-1:0] hwdata,
    output logic [DATA_WIDTH-1:0] hrdata,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic                  hsel,
    input  logic                  hready_in,
    output logic                  hready_out,
    output logic                  hresp,
    input  logic                  trig_in,
    input  logic                  cim_done,
    output logic                  trig_out,
    output logic                  irq
);

    logic                 ctrl_en, ctrl_irq_en;
    logic [15:0]          holdoff;
    logic                 clr_issued, clr_dropped, clr_sticky;
    reflex_state_e        state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 trig_in_q, trig_in_dly_q;
    logic                 trig_out_q, trig_out_d;
    logic                 pending_q, pending_d;
    logic                 sticky_q, sticky_d;
    logic [CNT_WIDTH-1:0] issued_q, issued_d;
    logic [CNT_WIDTH-1:0] dropped_q, dropped_d;
    logic                 ev, fire, set_sticky;

    reflex_ahb_regs #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_regs (
        .clk         (clk),
        .rst         (rst),
        .haddr       (haddr),
        .hwdata      (hwdata),
        .hrdata      (hrdata),
        .hwrite      (hwrite),
        .htrans      (htrans),
        .hsel        (hsel),
        .hready_in   (hready_in),
        .hready_out  (hready_out),
        .hresp       (hresp),
        .ctrl_en     (ctrl_en),
        .ctrl_irq_en (ctrl_irq_en),
        .holdoff     (holdoff),
        .clr_issued  (clr_issued),
        .clr_dropped (clr_dropped),
        .clr_sticky  (clr_sticky),
        .st_state    (state_q),
        .st_pending  (pending_q),
        .st_sticky   (sticky_q),
        .issued      (issued_q),
        .dropped     (dropped_q)
    );

    // trig_in is registered once before edge detection, giving the two-cycle trigger latency.
    assign ev = trig_in_q & ~trig_in_dly_q & ctrl_en;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        trig_out_d = 1'b0;
        fire       = 1'b0;
        set_sticky = 1'b0;
        unique case (state_q)
            StIdle: begin
                if ((ev || pending_q) && ctrl_en) begin
                    fire       = 1'b1;
                    state_d    = StFire;
                    cnt_d      = 32'(PULSE_CYCLES - 1);
                    trig_out_d = 1'b1;
                end
            end
            StFire: begin
                if (cnt_q == 32'd0) begin
                    state_d = StWait;
                end else begin
                    cnt_d      = cnt_q - 32'd1;
                    trig_out_d = 1'b1;
                end
            end
            StWait: begin
                if (cim_done) begin
                    state_d = StHold;
                    cnt_d   = 32'(holdoff);
                end else if (cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = StHold;
                    cnt_d      = 32'(holdoff);
                    set_sticky = 1'b1;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StHold: begin
                // A holdoff of 0 or 1 both give a single HOLD cycle.
                if (cnt_q <= 32'd1) begin
                    state_d = StIdle;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        pending_d = pending_q;
        dropped_d = dropped_q;
        if (fire) begin
            pending_d = 1'b0;
        end else if (ev && state_q != StIdle) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (dropped_q != '1) begin
                dropped_d = dropped_q + 1'b1;
            end
        end
        if (!ctrl_en) pending_d = 1'b0;
        if (clr_dropped) dropped_d = '0;

        issued_d = issued_q;
        if (clr_issued) begin
            issued_d = '0;
        end else if (fire && issued_q != '1) begin
            issued_d = issued_q + 1'b1;
        end

        sticky_d = (sticky_q & ~clr_sticky) | set_sticky;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 32'd0;
            trig_in_q     <= 1'b0;
            trig_in_dly_q <= 1'b0;
            trig_out_q    <= 1'b0;
            pending_q     <= 1'b0;
            sticky_q      <= 1'b0;
            issued_q      <= '0;
            dropped_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            trig_in_q     <= trig_in;
            trig_in_dly_q <= trig_in_q;
            trig_out_q    <= trig_out_d;
            pending_q     <= pending_d;
            sticky_q      <= sticky_d;
            issued_q      <= issued_d;
            dropped_q     <= dropped_d;
        end
    end

    assign trig_out = trig_out_q;
    assign irq      = sticky_q & ctrl_irq_en;

endmodule

// File: tb/tb_reflex_trigger_conditioner.sv
// Directed self-checking bench for reflex_trigger_conditioner; inputs change and outputs are
// sampled on the falling clock edge, "cycle c" is the period following rising edge c.
module tb_reflex_trigger_conditioner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] haddr = '0;
    logic [31:0] hwdata = '0;
    logic [31:0] hrdata;
    logic        hwrite = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic        hsel = 1'b0;
    logic        hready_in = 1'b1;
    logic        hready_out, hresp;
    logic        trig_in = 1'b0;
    logic        cim_done = 1'b0;
    logic        trig_out, irq;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] rd;
    logic        exp;

    always #5 clk = ~clk;

    reflex_trigger_conditioner #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .PULSE_CYCLES   (4),
        .TIMEOUT_CYCLES (40),
        .CNT_WIDTH      (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .hrdata     (hrdata),
        .hwrite     (hwrite),
        .htrans     (htrans),
        .hsel       (hsel),
        .hready_in  (hready_in),
        .hready_out (hready_out),
        .hresp      (hresp),
        .trig_in    (trig_in),
        .cim_done   (cim_done),
        .trig_out   (trig_out),
        .irq        (irq)
    );

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Two cycles: address phase then data phase; register is updated on return.
    task automatic ahb_write(input logic [4:0] a, input logic [31:0] d);
        haddr = {27'd0, a}; hwrite = 1'b1; htrans = 2'b10; hsel = 1'b1;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = d;
        @(negedge clk);
        hwdata = '0;
    endtask

    // One cycle: returns the register contents as they were during the address-phase cycle.
    task automatic ahb_read(input logic [4:0] a, output logic [31:0] d);
        haddr = {27'd0, a}; hwrite = 1'b0; htrans = 2'b10; hsel = 1'b1;
        @(negedge clk);
        hsel = 1'b0; htrans = 2'b00;
        d = hrdata;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [4:0]  offs [5];
        logic [31:0] exps [5];
        offs = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
        exps = '{32'd0, 32'd100, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 5; i++) begin
            ahb_read(offs[i], rd);
            n_checks++;
            if (rd !== exps[i]) begin
                n_fail++;
                $display("FAIL %s reg 0x%0h: got %0h expected %0h", tag, offs[i], rd, exps[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        n_checks++;
        if ({trig_out, irq, hready_out, hresp} !== 4'b0010) begin
            n_fail++;
            $display("FAIL reset_outputs: got trig=%b irq=%b hready=%b hresp=%b expected 0 0 1 0",
                     trig_out, irq, hready_out, hresp);
        end
        n_checks++;
        if (hrdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_hrdata: got %0h expected 0", hrdata);
        end
        check_reset_regs("reset");
    endtask

    task automatic test_single;
        ahb_write(5'h04, 32'd10);
        ahb_write(5'h00, 32'd1);
        for (int c = 0; c < 20; c++) begin
            exp = (c >= 2 && c <= 5);
            n_checks++;
            if (trig_out !== exp) begin
                n_fail++;
                $display("FAIL single_trig_out c%0d: got %b expected %b", c, trig_out, exp);
            end
            trig_in = (c < 3);
            @(negedge clk);
        end
        cim_done = 1'b1;
        @(negedge clk);
        cim_done = 1'b0;
        cyc(9);
        ahb_read(5'h08, rd);
        n_checks++;
        if (rd !== 32'h3) begin
            n_fail++;
            $display("FAIL single_status_c30: got %0h expected 3", rd);
        end
        ahb_read(5'h08, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL single_status_c31: got %0h expected 0", rd);
        end
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL single_issued: got %0h expected 1", rd);
        end
    endtask

    task automatic test_burst;
        ahb_write(5'h0C, 32'd0);
        ahb_write(5'h10, 32'd0);
        for (int c = 0; c <= 36; c++) begin
            trig_in  = (c == 0) || (c == 8) || (c == 10);
            cim_done = (c == 20);
            if (c == 31 || c == 32 || c == 35 || c == 36) begin
                exp = (c == 32 || c == 35);
                n_checks++;
                if (trig_out !== exp) begin
                    n_fail++;
                    $display("FAIL burst_trig_out c%0d: got %b expected %b", c, trig_out, exp);
                end
            end
            if (c == 14) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h6) begin
                    n_fail++;
                    $display("FAIL burst_status_pending: got %0h expected 6", rd);
                end
            end else if (c == 15) begin
                ahb_read(5'h10, rd);
                n_checks++;
                if (rd !== 32'd1) begin
                    n_fail++;
                    $display("FAIL burst_dropped: got %0h expected 1", rd);
                end
            end else begin
                @(negedge clk);
            end
        end
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL burst_issued: got %0h expected 2", rd);
        end
        ahb_read(5'h08, rd);
        n_checks++;
        if (rd !== 32'h2) begin
            n_fail++;
            $display("FAIL burst_status_after: got %0h expected 2", rd);
        end
        cim_done = 1'b1;
        @(negedge clk);
        cim_done = 1'b0;
        cyc(14);
    endtask

    task automatic test_timeout;
        ahb_write(5'h00, 32'd3);
        for (int c = 0; c <= 47; c++) begin
            trig_in = (c == 0);
            if (c == 45 || c == 47) begin
                exp = (c == 47);
                n_checks++;
                if (irq !== exp) begin
                    n_fail++;
                    $display("FAIL timeout_irq c%0d: got %b expected %b", c, irq, exp);
                end
            end
            if (c == 45) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h2) begin
                    n_fail++;
                    $display("FAIL timeout_status_c45: got %0h expected 2", rd);
                end
            end else if (c == 46) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'hB) begin
                    n_fail++;
                    $display("FAIL timeout_status_c46: got %0h expected b", rd);
                end
            end else begin
                @(negedge clk);
            end
        end
        cyc(10);
        ahb_write(5'h08, 32'h8);
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_w1c_irq: got %b expected 0", irq);
        end
        ahb_read(5'h08, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL timeout_w1c_status: got %0h expected 0", rd);
        end
        // cim_done on the last WAIT cycle must win over the timeout.
        for (int c = 0; c <= 46; c++) begin
            trig_in  = (c == 0);
            cim_done = (c == 45);
            if (c == 46) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h3) begin
                    n_fail++;
                    $display("FAIL done_on_timeout_status: got %0h expected 3", rd);
                end
            end else begin
                @(negedge clk);
            end
        end
        n_checks++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL done_on_timeout_irq: got %b expected 0", irq);
        end
        cyc(12);
    endtask

    task automatic test_disable;
        ahb_write(5'h00, 32'd1);
        ahb_write(5'h04, 32'd5);
        ahb_write(5'h0C, 32'd0);
        ahb_write(5'h10, 32'd0);
        for (int c = 0; c <= 40; c++) begin
            trig_in  = (c == 0) || (c == 8) || (c == 30);
            cim_done = (c == 20);
            if (c >= 16) begin
                n_checks++;
                if (trig_out !== 1'b0) begin
                    n_fail++;
                    $display("FAIL disable_trig_out c%0d: got %b expected 0", c, trig_out);
                end
            end
            if (c == 11) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h6) begin
                    n_fail++;
                    $display("FAIL disable_status_before: got %0h expected 6", rd);
                end
            end else if (c == 12) begin
                ahb_write(5'h00, 32'd0);
                c++;
            end else if (c == 15) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h2) begin
                    n_fail++;
                    $display("FAIL disable_status_after: got %0h expected 2", rd);
                end
            end else begin
                @(negedge clk);
            end
        end
        ahb_read(5'h08, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL disable_status_end: got %0h expected 0", rd);
        end
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'd1) begin
            n_fail++;
            $display("FAIL disable_issued: got %0h expected 1", rd);
        end
    endtask

    task automatic test_boundaries;
        ahb_write(5'h00, 32'd1);
        ahb_write(5'h04, 32'd0);
        ahb_write(5'h0C, 32'd0);
        // HOLDOFF=0 gives one HOLD cycle; an edge landing on it is queued and fires.
        for (int c = 0; c <= 17; c++) begin
            trig_in  = (c == 0) || (c == 10);
            cim_done = (c == 10);
            if (c == 12 || c == 13 || c == 16 || c == 17) begin
                exp = (c == 13 || c == 16);
                n_checks++;
                if (trig_out !== exp) begin
                    n_fail++;
                    $display("FAIL hold_edge_trig_out c%0d: got %b expected %b", c, trig_out, exp);
                end
            end
            if (c == 11) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h3) begin
                    n_fail++;
                    $display("FAIL holdoff0_status_c11: got %0h expected 3", rd);
                end
            end else if (c == 12) begin
                ahb_read(5'h08, rd);
                n_checks++;
                if (rd !== 32'h4) begin
                    n_fail++;
                    $display("FAIL holdoff0_status_c12: got %0h expected 4", rd);
                end
            end else begin
                @(negedge clk);
            end
        end
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'd2) begin
            n_fail++;
            $display("FAIL hold_edge_issued: got %0h expected 2", rd);
        end
        cim_done = 1'b1;
        @(negedge clk);
        cim_done = 1'b0;
        cyc(3);
        // Counters are 4 bits wide in this bench: 17 firings must stick at 0xF.
        ahb_write(5'h0C, 32'd0);
        for (int k = 0; k < 17; k++) begin
            trig_in = 1'b1;
            cyc(1);
            trig_in = 1'b0;
            cyc(6);
            cim_done = 1'b1;
            cyc(1);
            cim_done = 1'b0;
            cyc(1);
        end
        cyc(2);
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'hF) begin
            n_fail++;
            $display("FAIL issued_saturate: got %0h expected f", rd);
        end
        ahb_write(5'h0C, 32'h1234);
        ahb_read(5'h0C, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL issued_write_clear: got %0h expected 0", rd);
        end
        ahb_write(5'h1C, 32'hFFFF_FFFF);
        ahb_read(5'h1C, rd);
        n_checks++;
        if (rd !== 32'h0) begin
            n_fail++;
            $display("FAIL unmapped_read: got %0h expected 0", rd);
        end
        ahb_read(5'h00, rd);
        n_checks++;
        if (rd !== 32'h1) begin
            n_fail++;
            $display("FAIL unmapped_write_ctrl: got %0h expected 1", rd);
        end
    endtask

    task automatic test_reset_mid_pulse;
        ahb_write(5'h04, 32'd7);
        trig_in = 1'b1;
        cyc(1);
        trig_in = 1'b0;
        cyc(1);
        n_checks++;
        if (trig_out !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pulse_c2: got %b expected 1", trig_out);
        end
        rst = 1'b1;
        cyc(1);
        n_checks++;
        if (trig_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pulse_c3: got %b expected 0", trig_out);
        end
        rst = 1'b0;
        n_checks++;
        if ({irq, hrdata} !== 33'd0) begin
            n_fail++;
            $display("FAIL rst_pulse_outputs: got irq=%b hrdata=%0h expected 0 0", irq, hrdata);
        end
        check_reset_regs("rst_mid_pulse");
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst;
        test_timeout;
        test_disable;
        test_boundaries;
        test_reset_mid_pulse;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
